// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen, ship, missile constants and missile FSM states
package game_pkg;

    localparam int POS_W         = 12;
    localparam int SCREEN_W      = 1024;
    localparam int SCREEN_H      = 768;
    localparam int SHIP_WIDTH    = 48;
    localparam int SHIP_HEIGHT   = 64;
    localparam int SHIP_Y_TOP    = SCREEN_H - SHIP_HEIGHT;
    localparam int MISSLE_WIDTH  = 8;
    localparam int MISSLE_HEIGHT = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLY      = 2'd1,
        ST_HIT      = 2'd2,
        ST_COOLDOWN = 2'd3
    } missle_state_t;

endpackage

// File: rtl/enemy_missle_ctl_if.sv
// rtl/enemy_missle_ctl_if.sv - formation/draw side bundle of the enemy missile controller
interface enemy_missle_ctl_if;
    import game_pkg::*;

    logic             fire_req;
    logic [POS_W-1:0] enemy_xpos_in;
    logic [POS_W-1:0] enemy_ypos_in;
    logic [POS_W-1:0] ship_xpos_in;
    logic             ship_dead;
    logic [POS_W-1:0] xpos_out;
    logic [POS_W-1:0] ypos_out;
    logic             on_out;
    logic             ship_hit;
    logic             busy;

    modport master (
        output fire_req, enemy_xpos_in, enemy_ypos_in, ship_xpos_in, ship_dead,
        input  xpos_out, ypos_out, on_out, ship_hit, busy
    );

    modport slave (
        input  fire_req, enemy_xpos_in, enemy_ypos_in, ship_xpos_in, ship_dead,
        output xpos_out, ypos_out, on_out, ship_hit, busy
    );

endinterface

// File: rtl/rect_overlap.sv
// rtl/rect_overlap.sv - combinational AABB overlap of two 12-bit rectangles
module rect_overlap (
    input  logic [11:0] a_x,
    input  logic [11:0] a_y,
    input  logic [11:0] a_w,
    input  logic [11:0] a_h,
    input  logic [11:0] b_x,
    input  logic [11:0] b_y,
    input  logic [11:0] b_w,
    input  logic [11:0] b_h,
    output logic        overlap
);

    // 13-bit right/bottom edges so an edge near 4095 cannot wrap
    logic [12:0] a_r, a_b, b_r, b_b;

    assign a_r = {1'b0, a_x} + {1'b0, a_w};
    assign a_b = {1'b0, a_y} + {1'b0, a_h};
    assign b_r = {1'b0, b_x} + {1'b0, b_w};
    assign b_b = {1'b0, b_y} + {1'b0, b_h};

    assign overlap = ({1'b0, a_x} < b_r) && ({1'b0, b_x} < a_r) &&
                     ({1'b0, a_y} < b_b) && ({1'b0, b_y} < a_b);

endmodule

// File: rtl/enemy_missle_ctl.sv
// rtl/enemy_missle_ctl.sv - single enemy missile: launch, descend, ship hit pulse, cooldown
module enemy_missle_ctl
    import game_pkg::*;
#(
    parameter int COUNTER_LIMIT  = 90000,
    parameter int STEP           = 1,
    parameter int Y_LIMIT        = 767,
    parameter int COOLDOWN_LIMIT = 200000
) (
    input  logic               pclk,
    input  logic               rst,
    enemy_missle_ctl_if.slave  bus
);

    localparam int RW = $clog2(COUNTER_LIMIT + 2);
    localparam int CW = $clog2(COOLDOWN_LIMIT + 2);
    localparam logic [RW-1:0]    R_MAX = RW'(COUNTER_LIMIT);
    localparam logic [CW-1:0]    C_MAX = CW'(COOLDOWN_LIMIT);
    localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_LIMIT);
    localparam logic [POS_W-1:0] Y_INC = POS_W'(STEP);

    missle_state_t    state, state_n;
    logic [RW-1:0]    refresh_cnt, refresh_cnt_n;
    logic [CW-1:0]    cool_cnt, cool_cnt_n;
    logic [POS_W-1:0] xpos_n, ypos_n;
    logic             on_n, hit_n, busy_n;
    logic             overlap;

    // Ship sits on the bottom of the play field, so its box is extended to the
    // end of the coordinate space: any missile row below SHIP_Y_TOP counts.
    rect_overlap u_overlap (
        .a_x     (bus.xpos_out),
        .a_y     (bus.ypos_out),
        .a_w     (12'(MISSLE_WIDTH)),
        .a_h     (12'(MISSLE_HEIGHT)),
        .b_x     (bus.ship_xpos_in),
        .b_y     (12'(SHIP_Y_TOP)),
        .b_w     (12'(SHIP_WIDTH)),
        .b_h     (12'hFFF),
        .overlap (overlap)
    );

    always_comb begin
        state_n       = state;
        refresh_cnt_n = refresh_cnt;
        cool_cnt_n    = cool_cnt;
        xpos_n        = bus.xpos_out;
        ypos_n        = bus.ypos_out;
        on_n          = bus.on_out;
        hit_n         = 1'b0;
        case (state)
            ST_IDLE: begin
                on_n          = 1'b0;
                refresh_cnt_n = '0;
                cool_cnt_n    = '0;
                if (bus.fire_req && !bus.ship_dead) begin
                    xpos_n  = bus.enemy_xpos_in;
                    ypos_n  = bus.enemy_ypos_in;
                    on_n    = 1'b1;
                    state_n = ST_FLY;
                end
            end
            ST_FLY: begin
                if (bus.ship_dead) begin
                    on_n          = 1'b0;
                    refresh_cnt_n = '0;
                    state_n       = ST_IDLE;
                end else if (overlap) begin
                    on_n          = 1'b0;
                    hit_n         = 1'b1;
                    refresh_cnt_n = '0;
                    state_n       = ST_HIT;
                end else if (bus.ypos_out >= Y_LIM) begin
                    on_n          = 1'b0;
                    refresh_cnt_n = '0;
                    state_n       = ST_COOLDOWN;
                end else if (refresh_cnt == R_MAX) begin
                    refresh_cnt_n = '0;
                    ypos_n        = bus.ypos_out + Y_INC;
                end else begin
                    refresh_cnt_n = refresh_cnt + RW'(1);
                end
            end
            ST_HIT: begin
                on_n    = 1'b0;
                state_n = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                on_n = 1'b0;
                if (cool_cnt == C_MAX) begin
                    cool_cnt_n = '0;
                    state_n    = ST_IDLE;
                end else begin
                    cool_cnt_n = cool_cnt + CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= ST_IDLE;
            refresh_cnt  <= '0;
            cool_cnt     <= '0;
            bus.xpos_out <= '0;
            bus.ypos_out <= '0;
            bus.on_out   <= 1'b0;
            bus.ship_hit <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            state        <= state_n;
            refresh_cnt  <= refresh_cnt_n;
            cool_cnt     <= cool_cnt_n;
            bus.xpos_out <= xpos_n;
            bus.ypos_out <= ypos_n;
            bus.on_out   <= on_n;
            bus.ship_hit <= hit_n;
            bus.busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_enemy_missle_ctl.sv
// tb/tb_enemy_missle_ctl.sv - directed self-checking bench for enemy_missle_ctl
module tb_enemy_missle_ctl;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    enemy_missle_ctl_if bus ();

    enemy_missle_ctl #(
        .COUNTER_LIMIT  (3),
        .STEP           (4),
        .COOLDOWN_LIMIT (5)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic launch(input logic [11:0] ex, input logic [11:0] ey, input logic [11:0] sx);
        bus.enemy_xpos_in = ex;
        bus.enemy_ypos_in = ey;
        bus.ship_xpos_in  = sx;
        bus.fire_req      = 1'b1;
        tick(1);
        bus.fire_req      = 1'b0;
    endtask

    // packs every output so a single vector covers the whole output state
    function automatic logic [31:0] outs();
        return {3'b0, bus.on_out, bus.busy, bus.ship_hit, bus.xpos_out, bus.ypos_out, 2'b0};
    endfunction

    initial begin
        bus.fire_req      = 1'b0;
        bus.enemy_xpos_in = '0;
        bus.enemy_ypos_in = '0;
        bus.ship_xpos_in  = '0;
        bus.ship_dead     = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            chk("idle_outs", outs(), 32'd0);
            tick(1);
        end

        // launch and miss
        launch(12'd100, 12'd600, 12'd500);
        chk("miss_on", bus.on_out, 1);
        chk("miss_x", bus.xpos_out, 100);
        chk("miss_y0", bus.ypos_out, 600);
        chk("miss_busy", bus.busy, 1);
        tick(3);
        chk("miss_y_hold", bus.ypos_out, 600);
        tick(1);
        chk("miss_y_step", bus.ypos_out, 604);
        tick(163);
        chk("miss_y764", bus.ypos_out, 764);
        chk("miss_on764", bus.on_out, 1);
        tick(1);
        chk("miss_y768", bus.ypos_out, 768);
        chk("miss_on768", bus.on_out, 1);
        tick(1);
        chk("miss_retired_on", bus.on_out, 0);
        chk("miss_cool_busy", bus.busy, 1);
        chk("miss_y_kept", bus.ypos_out, 768);
        chk("miss_x_kept", bus.xpos_out, 100);
        chk("miss_no_hit", bus.ship_hit, 0);
        tick(5);
        chk("miss_cool_end_busy", bus.busy, 1);
        tick(1);
        chk("miss_idle_busy", bus.busy, 0);

        // direct hit
        launch(12'd520, 12'd680, 12'd500);
        chk("hit_y0", bus.ypos_out, 680);
        tick(11);
        chk("hit_y688", bus.ypos_out, 688);
        chk("hit_pre_hit", bus.ship_hit, 0);
        tick(1);
        chk("hit_y692", bus.ypos_out, 692);
        chk("hit_on692", bus.on_out, 1);
        tick(1);
        chk("hit_pulse", bus.ship_hit, 1);
        chk("hit_on_off", bus.on_out, 0);
        chk("hit_busy", bus.busy, 1);
        tick(1);
        chk("hit_pulse_end", bus.ship_hit, 0);
        tick(5);
        chk("hit_cool_busy", bus.busy, 1);
        tick(1);
        chk("hit_idle", bus.busy, 0);

        // edge overlap: launch already past Y_LIMIT
        launch(12'd500, 12'd768, 12'd540);
        chk("edge_on_1cyc", bus.on_out, 1);
        tick(1);
        chk("edge540_on", bus.on_out, 0);
        chk("edge540_nohit", bus.ship_hit, 0);
        chk("edge540_busy", bus.busy, 1);
        tick(5);
        chk("edge540_cool", bus.busy, 1);
        tick(1);
        chk("edge540_idle", bus.busy, 0);
        launch(12'd500, 12'd768, 12'd507);
        tick(1);
        chk("edge507_hit", bus.ship_hit, 1);
        chk("edge507_on", bus.on_out, 0);
        tick(1);
        chk("edge507_hit_end", bus.ship_hit, 0);
        tick(5);
        chk("edge507_cool", bus.busy, 1);
        tick(1);
        chk("edge507_idle", bus.busy, 0);

        // ship_dead mid-flight
        launch(12'd100, 12'd642, 12'd500);
        tick(8);
        chk("dead_y650", bus.ypos_out, 650);
        bus.ship_dead = 1'b1;
        tick(1);
        chk("dead_on", bus.on_out, 0);
        chk("dead_busy", bus.busy, 0);
        chk("dead_hit", bus.ship_hit, 0);
        bus.fire_req = 1'b1;
        tick(3);
        chk("dead_nolaunch_on", bus.on_out, 0);
        chk("dead_nolaunch_busy", bus.busy, 0);
        bus.fire_req  = 1'b0;
        bus.ship_dead = 1'b0;

        // ship_dead together with overlap aborts without a hit
        launch(12'd100, 12'd700, 12'd96);
        chk("deadov_on", bus.on_out, 1);
        bus.ship_dead = 1'b1;
        tick(1);
        chk("deadov_hit", bus.ship_hit, 0);
        chk("deadov_busy", bus.busy, 0);
        chk("deadov_on_off", bus.on_out, 0);
        bus.ship_dead = 1'b0;

        // fire_req held: one launch per IDLE visit
        bus.ship_xpos_in  = 12'd500;
        bus.enemy_xpos_in = 12'd100;
        bus.enemy_ypos_in = 12'd760;
        bus.fire_req      = 1'b1;
        tick(1);
        chk("held_on", bus.on_out, 1);
        chk("held_y0", bus.ypos_out, 760);
        tick(8);
        chk("held_y768", bus.ypos_out, 768);
        tick(1);
        chk("held_retired", bus.on_out, 0);
        tick(5);
        chk("held_cool", bus.busy, 1);
        chk("held_cool_on", bus.on_out, 0);
        tick(1);
        chk("held_idle", bus.busy, 0);
        bus.enemy_xpos_in = 12'd200;
        tick(1);
        chk("held_relaunch_on", bus.on_out, 1);
        chk("held_relaunch_x", bus.xpos_out, 200);
        chk("held_relaunch_y", bus.ypos_out, 760);

        // reset mid-flight
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("rst_outs", outs(), 32'd0);
        tick(1);
        chk("rst_held_outs", outs(), 32'd0);
        rst = 1'b0;
        bus.fire_req = 1'b0;
        tick(2);
        chk("post_rst_outs", outs(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
